// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: size encoding,
// FSM states, latency bounds and the alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    localparam int CNT_W       = 3;

    // True when the access size/alignment combination cannot be served.
    function automatic logic size_align_err(input mem_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// plus lane selection and sign/zero extension of load data.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] ldata
);

    logic [7:0] rbyte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbyte
            assign rbyte[gi] = rdata[gi*8 +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rbyte[addr_lo];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        ldata  = 32'h0;
        case (size)
            SZ_BYTE: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
                ldata  = {{24{~zext & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
                ldata  = {{16{~zext & sel_half[15]}}, sel_half};
            end
            // Word loads ignore zext: there is nothing left to extend.
            SZ_WORD: begin
                be     = 4'b1111;
                wlanes = wdata;
                ldata  = rdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wdata;
                ldata  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store, waits LATENCY
// edges, then pulses a single response cycle. Memory is four byte-lane RAMs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               we_reg;
    mem_size_e          size_reg;
    logic               zext_reg;
    logic [31:0]        addr_reg;
    logic [31:0]        wdata_reg;

    logic               accept;
    logic               bypass;
    logic               enter_resp;
    logic               mem_we;

    logic               cur_we;
    mem_size_e          cur_size;
    logic               cur_zext;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic               cur_err;
    logic [AW-1:0]      idx;

    logic [3:0]         be;
    logic [31:0]        wlanes;
    logic [31:0]        ldata;
    logic [31:0]        rd_word;

    assign accept = req_valid && req_ready;

    // With LATENCY=1 memory is touched on the accepting edge itself, before the
    // request registers hold anything, so the live inputs feed the datapath.
    assign bypass    = (LATENCY == LATENCY_MIN) && (state_reg == IDLE);
    assign cur_we    = bypass ? req_we                  : we_reg;
    assign cur_size  = bypass ? mem_size_e'(req_size)   : size_reg;
    assign cur_zext  = bypass ? req_unsigned            : zext_reg;
    assign cur_addr  = bypass ? req_addr                : addr_reg;
    assign cur_wdata = bypass ? req_wdata               : wdata_reg;

    assign cur_err = size_align_err(cur_size, cur_addr[1:0]) ||
                     ({2'b00, cur_addr[31:2]} >= DEPTH_L);
    assign idx     = cur_addr[AW+1:2];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            size_reg  <= SZ_BYTE;
            zext_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            we_reg    <= req_we;
            size_reg  <= mem_size_e'(req_size);
            zext_reg  <= req_unsigned;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == LATENCY_MIN) begin
                        state_next = RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_reg == IDLE) && !reset;
        rsp_valid = (state_reg == RESP);
        rsp_err   = rsp_valid && cur_err;
        rsp_rdata = (rsp_valid && !cur_err && !cur_we) ? ldata : 32'h0;
    end

    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign mem_we     = enter_resp && cur_we && !cur_err;

    dmem_lane_unit u_lane (
        .size    (cur_size),
        .addr_lo (cur_addr[1:0]),
        .zext    (cur_zext),
        .wdata   (cur_wdata),
        .rdata   (rd_word),
        .be      (be),
        .wlanes  (wlanes),
        .ldata   (ldata)
    );

    // One RAM per byte lane; the read register captures contents as they were
    // at the edge entering RESP.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (mem_we && be[gi]) begin
                    mem[idx] <= wlanes[gi*8 +: 8];
                end
                if (enter_resp) begin
                    rd_reg <= mem[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule
